// File: rtl/data_ram_be.sv
// Byte-lane data memory with RV load/store sizing, write-first bypass and a zero-fill sweep
// after reset. Define RAM_PARITY_EN to add per-lane even parity with a PINJ error-inject input.
module data_ram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                                           CLK,
    input  logic                                           RST,
    input  logic                                           ENABLE_W,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]     ADDR_W,
    input  logic [2:0]                                     FUNCT3_W,
    input  logic [DATA_WIDTH-1:0]                          Q_W,
    input  logic                                           ENABLE_R,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]     ADDR_R,
    input  logic [2:0]                                     FUNCT3_R,
    output logic [DATA_WIDTH-1:0]                          Q_R,
    output logic                                           VALID_R,
    output logic                                           ERR_W,
    output logic                                           ERR_R,
    output logic                                           BUSY,
`ifdef RAM_PARITY_EN
    input  logic                                           PINJ,
`endif
    output logic                                           PERR
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OW    = $clog2(NB);
    localparam int unsigned BA    = ADDR_WIDTH + OW;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] q_r_q;
    logic                  valid_q, err_w_q, err_r_q;
    logic                  run;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store decode
    int unsigned           w_size;
    logic                  w_legal, w_do;
    logic [OW-1:0]         w_off;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [NB-1:0]         w_mask;
    logic [DATA_WIDTH-1:0] w_data;

    // Load decode and datapath
    int unsigned           r_size;
    logic                  r_legal, r_sgn, r_ok;
    logic [OW-1:0]         r_off;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] rd_word, rd_shift, ext;
    logic                  msb;

`ifdef RAM_PARITY_EN
    logic [NB-1:0]         par_mem [DEPTH];
    logic [NB-1:0]         rd_par;
    logic                  perr_any, perr_q;
`endif

    assign run = (state_q == StRun);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = StRun;
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        w_size  = 0;
        w_legal = 1'b1;
        case (FUNCT3_W)
            3'b000: w_size = 1;
            3'b001: w_size = 2;
            3'b010: w_size = 4;
            3'b011: begin
                w_size  = 8;
                w_legal = (DATA_WIDTH == 64);
            end
            default: w_legal = 1'b0;
        endcase
        w_off  = ADDR_W[OW-1:0];
        w_word = ADDR_W[BA-1:OW];
        w_do   = run && ENABLE_W && w_legal && ((32'(w_off) & (w_size - 1)) == 0);
        for (int unsigned i = 0; i < NB; i++) begin
            w_mask[i] = w_do && (i >= 32'(w_off)) && (i < 32'(w_off) + w_size);
        end
        w_data = Q_W << {w_off, 3'b000};
    end

    always_comb begin
        r_size  = 0;
        r_sgn   = 1'b1;
        r_legal = 1'b1;
        case (FUNCT3_R)
            3'b000: r_size = 1;
            3'b001: r_size = 2;
            3'b010: r_size = 4;
            3'b100: begin r_size = 1; r_sgn = 1'b0; end
            3'b101: begin r_size = 2; r_sgn = 1'b0; end
            3'b011: begin
                r_size  = 8;
                r_legal = (DATA_WIDTH == 64);
            end
            3'b110: begin
                r_size  = 4;
                r_sgn   = 1'b0;
                r_legal = (DATA_WIDTH == 64);
            end
            default: r_legal = 1'b0;
        endcase
        r_off  = ADDR_R[OW-1:0];
        r_word = ADDR_R[BA-1:OW];
        r_ok   = r_legal && ((32'(r_off) & (r_size - 1)) == 0);
    end

    // Write-first: lanes being stored this cycle override the array contents
    always_comb begin
        rd_word = mem[r_word];
        for (int unsigned i = 0; i < NB; i++) begin
            if (w_mask[i] && (w_word == r_word)) rd_word[8*i +: 8] = w_data[8*i +: 8];
        end
        rd_shift = rd_word >> {r_off, 3'b000};
        msb      = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i == r_size * 8 - 1) msb = rd_shift[i];
        end
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            ext[i] = (i < r_size * 8) ? rd_shift[i] : (r_sgn & msb);
        end
    end

`ifdef RAM_PARITY_EN
    always_comb begin
        rd_par   = par_mem[r_word];
        perr_any = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (w_mask[i] && (w_word == r_word)) rd_par[i] = (^w_data[8*i +: 8]) ^ PINJ;
            if ((i >= 32'(r_off)) && (i < 32'(r_off) + r_size) &&
                ((^rd_word[8*i +: 8]) != rd_par[i])) begin
                perr_any = 1'b1;
            end
        end
    end
`endif

    // Array is never reset; the sweep clears it one word per cycle
    always_ff @(posedge CLK) begin
        if (!run) begin
            mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
`ifdef RAM_PARITY_EN
            par_mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_mask[i]) begin
                    mem[w_word][8*i +: 8] <= w_data[8*i +: 8];
`ifdef RAM_PARITY_EN
                    par_mem[w_word][i] <= (^w_data[8*i +: 8]) ^ PINJ;
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StClear;
            cnt_q   <= '0;
            q_r_q   <= '0;
            valid_q <= 1'b0;
            err_w_q <= 1'b0;
            err_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= run && ENABLE_R;
            err_w_q <= run && ENABLE_W && !w_do;
            err_r_q <= run && ENABLE_R && !r_ok;
            if (run && ENABLE_R) q_r_q <= r_ok ? ext : '0;
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) perr_q <= 1'b0;
        else     perr_q <= run && ENABLE_R && r_ok && perr_any;
    end
    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

    assign Q_R     = q_r_q;
    assign VALID_R = valid_q;
    assign ERR_W   = err_w_q;
    assign ERR_R   = err_r_q;
    assign BUSY    = (state_q == StClear);

endmodule

// File: tb/tb_data_ram_be.sv
// Bench for data_ram_be (DATA_WIDTH=32, ADDR_WIDTH=4): directed vector table, random traffic
// against a byte-array model, and reset/sweep corner sequences.
module tb_data_ram_be;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE_W, ENABLE_R;
    logic [5:0]  ADDR_W, ADDR_R;
    logic [2:0]  FUNCT3_W, FUNCT3_R;
    logic [31:0] Q_W, Q_R;
    logic        VALID_R, ERR_W, ERR_R, BUSY, PERR;
`ifdef RAM_PARITY_EN
    logic        PINJ;
`endif

    data_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENABLE_W (ENABLE_W),
        .ADDR_W   (ADDR_W),
        .FUNCT3_W (FUNCT3_W),
        .Q_W      (Q_W),
        .ENABLE_R (ENABLE_R),
        .ADDR_R   (ADDR_R),
        .FUNCT3_R (FUNCT3_R),
        .Q_R      (Q_R),
        .VALID_R  (VALID_R),
        .ERR_W    (ERR_W),
        .ERR_R    (ERR_R),
        .BUSY     (BUSY),
`ifdef RAM_PARITY_EN
        .PINJ     (PINJ),
`endif
        .PERR     (PERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [2:0]  f3w;
        logic [5:0]  aw;
        logic [31:0] dw;
        logic        re;
        logic [2:0]  f3r;
        logic [5:0]  ar;
        logic [31:0] eq;
        logic        ew;
        logic        er;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mdl [64];
    logic [31:0] exp_q = '0;
    logic        tb_pinj = 1'b0;
    logic        tb_exp_perr = 1'b0;
    vec_t        tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [2:0] f3w, input logic [5:0] aw,
                                 input logic [31:0] dw, input logic re, input logic [2:0] f3r,
                                 input logic [5:0] ar, input logic [31:0] eq, input logic ew,
                                 input logic er);
        vec_t v;
        v.we = we; v.f3w = f3w; v.aw = aw; v.dw = dw; v.re = re;
        v.f3r = f3r; v.ar = ar; v.eq = eq; v.ew = ew; v.er = er;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [5:0] a, input logic [31:0] d,
                               output logic err);
        int sz;
        case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            default: sz = 0;
        endcase
        if (sz == 0 || (int'(a) % sz) != 0) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
            for (int k = 0; k < sz; k++) mdl[int'(a) + k] = d[8*k +: 8];
        end
    endtask

    task automatic model_load(input logic [2:0] f3, input logic [5:0] a, output logic [31:0] q,
                              output logic err);
        int          sz;
        bit          sgn;
        longint unsigned v;
        sgn = 1'b1;
        case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: begin sz = 1; sgn = 1'b0; end
            3'd5: begin sz = 2; sgn = 1'b0; end
            default: sz = 0;
        endcase
        if (sz == 0 || (int'(a) % sz) != 0) begin
            q = '0;
            err = 1'b1;
        end else begin
            err = 1'b0;
            v = 0;
            for (int k = 0; k < sz; k++) v = v | (longint'(mdl[int'(a) + k]) << (8 * k));
            if (sgn && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~((64'd1 << (8 * sz)) - 1);
            q = v[31:0];
        end
    endtask

    task automatic op(input logic we, input logic [2:0] f3w, input logic [5:0] aw,
                      input logic [31:0] dw, input logic re, input logic [2:0] f3r,
                      input logic [5:0] ar);
        logic        ew, er;
        logic [31:0] q;
        ew = 1'b0;
        er = 1'b0;
        ENABLE_W = we; FUNCT3_W = f3w; ADDR_W = aw; Q_W = dw;
        ENABLE_R = re; FUNCT3_R = f3r; ADDR_R = ar;
`ifdef RAM_PARITY_EN
        PINJ = tb_pinj;
`endif
        if (we) model_store(f3w, aw, dw, ew);
        if (re) begin
            model_load(f3r, ar, q, er);
            exp_q = q;
        end
        @(posedge CLK);
        #1;
        ENABLE_W = 1'b0;
        ENABLE_R = 1'b0;
        chk1("err_w", ERR_W, ew);
        chk1("valid_r", VALID_R, re);
        chk1("err_r", ERR_R, er);
        chk("q_r", Q_R, exp_q);
        chk1("perr", PERR, re & tb_exp_perr);
    endtask

    // Holds illegal/ignored requests during the sweep and returns the number of BUSY cycles
    task automatic count_busy(output int n);
        n = 0;
        ENABLE_W = 1'b1; FUNCT3_W = 3'd0; ADDR_W = 6'h00; Q_W = 32'hFF;
        ENABLE_R = 1'b1; FUNCT3_R = 3'd7; ADDR_R = 6'h00;
        while (BUSY && n < 100) begin
            chk1("busy_valid_r", VALID_R, 1'b0);
            chk1("busy_err_r", ERR_R, 1'b0);
            chk1("busy_err_w", ERR_W, 1'b0);
            n++;
            @(posedge CLK);
            #1;
        end
        ENABLE_W = 1'b0;
        ENABLE_R = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [5:0]  aw, ar;
        RST = 1'b1;
        ENABLE_W = 1'b0; ENABLE_R = 1'b0;
        ADDR_W = '0; ADDR_R = '0; FUNCT3_W = '0; FUNCT3_R = '0; Q_W = '0;
`ifdef RAM_PARITY_EN
        PINJ = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_busy", BUSY, 1'b1);
        chk("rst_q_r", Q_R, 32'h0);
        chk1("rst_valid_r", VALID_R, 1'b0);
        chk1("rst_err_w", ERR_W, 1'b0);
        chk1("rst_err_r", ERR_R, 1'b0);
        chk1("rst_perr", PERR, 1'b0);

        RST = 1'b0;
        count_busy(n);
        chk("busy_cycles", n, 16);
        for (int a = 0; a < 64; a += 4) op(1'b0, 3'd0, 6'h0, 32'h0, 1'b1, 3'd2, 6'(a));

        tbl[0]  = mkv(1, 3'd2, 6'h00, 32'h8000_80F0, 0, 3'd0, 6'h00, 32'h0, 0, 0);
        tbl[1]  = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd0, 6'h00, 32'hFFFF_FFF0, 0, 0);
        tbl[2]  = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd4, 6'h00, 32'h0000_00F0, 0, 0);
        tbl[3]  = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd1, 6'h02, 32'hFFFF_8000, 0, 0);
        tbl[4]  = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd5, 6'h00, 32'h0000_80F0, 0, 0);
        tbl[5]  = mkv(1, 3'd2, 6'h04, 32'h1122_3344, 0, 3'd0, 6'h00, 32'h0, 0, 0);
        tbl[6]  = mkv(1, 3'd0, 6'h05, 32'h0000_00AA, 0, 3'd0, 6'h00, 32'h0, 0, 0);
        tbl[7]  = mkv(1, 3'd1, 6'h06, 32'h0000_BEEF, 0, 3'd0, 6'h00, 32'h0, 0, 0);
        tbl[8]  = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd2, 6'h04, 32'hBEEF_AA44, 0, 0);
        tbl[9]  = mkv(1, 3'd2, 6'h08, 32'hCAFE_BABE, 0, 3'd0, 6'h00, 32'h0, 0, 0);
        tbl[10] = mkv(1, 3'd1, 6'h09, 32'h0000_1234, 1, 3'd2, 6'h0A, 32'h0, 1, 1);
        tbl[11] = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd2, 6'h08, 32'hCAFE_BABE, 0, 0);
        tbl[12] = mkv(1, 3'd3, 6'h08, 32'h0, 1, 3'd2, 6'h08, 32'hCAFE_BABE, 1, 0);
        tbl[13] = mkv(1, 3'd2, 6'h0C, 32'h1234_5678, 0, 3'd0, 6'h00, 32'h0, 0, 0);
        tbl[14] = mkv(1, 3'd0, 6'h0C, 32'h0000_0055, 1, 3'd2, 6'h0C, 32'h1234_5655, 0, 0);
        tbl[15] = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd6, 6'h00, 32'h0, 0, 1);
        tbl[16] = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd5, 6'h01, 32'h0, 0, 1);
        tbl[17] = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd1, 6'h06, 32'hFFFF_BEEF, 0, 0);
        tbl[18] = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd0, 6'h07, 32'hFFFF_FFBE, 0, 0);
        tbl[19] = mkv(0, 3'd0, 6'h00, 32'h0, 1, 3'd4, 6'h06, 32'h0000_00EF, 0, 0);
        for (int i = 0; i < 20; i++) begin
            op(tbl[i].we, tbl[i].f3w, tbl[i].aw, tbl[i].dw, tbl[i].re, tbl[i].f3r, tbl[i].ar);
            if (tbl[i].re) chk($sformatf("tbl%0d_q_r", i), Q_R, tbl[i].eq);
            chk1($sformatf("tbl%0d_err_w", i), ERR_W, tbl[i].ew);
            chk1($sformatf("tbl%0d_err_r", i), ERR_R, tbl[i].er);
        end

        for (int i = 0; i < 400; i++) begin
            aw = 6'($urandom_range(0, 63));
            ar = ($urandom_range(0, 3) == 0) ? aw : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) aw = aw & 6'h3C;
            if ($urandom_range(0, 2) != 0) ar = ar & 6'h3E;
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), aw, $urandom(),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ar);
        end

        // Asynchronous reset takes effect before the next clock edge
        op(1'b0, 3'd0, 6'h0, 32'h0, 1'b1, 3'd2, 6'h0C);
        RST = 1'b1;
        #1;
        chk1("async_rst_busy", BUSY, 1'b1);
        chk("async_rst_q_r", Q_R, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (7) begin
            @(posedge CLK);
            #1;
        end
        chk1("mid_sweep_busy", BUSY, 1'b1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q = '0;
        count_busy(n);
        chk("busy_cycles_restart", n, 16);
        for (int a = 0; a < 64; a += 4) op(1'b0, 3'd0, 6'h0, 32'h0, 1'b1, 3'd2, 6'(a));

`ifdef RAM_PARITY_EN
        tb_pinj = 1'b1;
        op(1'b1, 3'd2, 6'h10, 32'h0, 1'b0, 3'd0, 6'h00);
        tb_pinj = 1'b0;
        tb_exp_perr = 1'b1;
        op(1'b0, 3'd0, 6'h00, 32'h0, 1'b1, 3'd0, 6'h11);
        tb_exp_perr = 1'b0;
        op(1'b1, 3'd2, 6'h10, 32'h0, 1'b0, 3'd0, 6'h00);
        op(1'b0, 3'd0, 6'h00, 32'h0, 1'b1, 3'd0, 6'h11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
